// File: rtl/timestamp_pkg.sv
// Shared constants for the timestamp register front end: address map, CTRL bit positions, latch FSM encoding.
package timestamp_pkg;

  localparam int unsigned ADDR_CTRL = 32'h30;
  localparam int unsigned ADDR_TS0  = 32'h31;
  localparam int unsigned ADDR_TS1  = 32'h32;
  localparam int unsigned ADDR_TS2  = 32'h33;
  localparam int unsigned ADDR_TS3  = 32'h34;

  localparam int unsigned NUM_TS_WORDS = 4;

  // CTRL write bits
  localparam int unsigned CTRL_LATCH_BIT = 0;
  localparam int unsigned CTRL_RST_BIT   = 1;
  // CTRL read bits
  localparam int unsigned CTRL_BUSY_BIT  = 0;
  localparam int unsigned CTRL_VALID_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CAPT = 2'd2
  } latch_state_e;

endpackage

// File: rtl/pulse_stretch.sv
// Fixed-length pulse generator: a start in cycle N drives pulse high for N+1..N+LEN; a new start restarts the count.
module pulse_stretch #(
  parameter int unsigned LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic pulse
);

  localparam int unsigned CNT_WD = (LEN > 1) ? $clog2(LEN) : 1;

  logic [CNT_WD-1:0] cnt;

  // cnt holds the number of high cycles still owed after the current one
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (start) begin
      cnt   <= CNT_WD'(LEN - 1);
      pulse <= 1'b1;
    end else if (cnt != '0) begin
      cnt   <= cnt - CNT_WD'(1);
      pulse <= 1'b1;
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/timestamp_reg_if.sv
// Register-bus front end for the timestamp counter: CTRL decode, load/capture FSM feeding a coherent
// 64-bit shadow, shadow read mux, and the counter soft-reset pulse.
module timestamp_reg_if
  import timestamp_pkg::*;
#(
  parameter int unsigned LONG_REG_WD = 64,
  parameter int unsigned REG_WD      = 16,
  parameter int unsigned ADDR_WD     = 9,
  parameter int unsigned RST_LEN     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_wr_en,
  input  logic                   i_rd_en,
  input  logic [ADDR_WD-1:0]     iv_addr,
  input  logic [REG_WD-1:0]      iv_wr_data,
  output logic [REG_WD-1:0]      ov_rd_data,
  output logic                   o_rd_valid,
  output logic                   o_timestamp_load,
  input  logic [LONG_REG_WD-1:0] iv_timestamp_reg,
  output logic                   o_timestamp_rst
);

  latch_state_e           state;
  logic [LONG_REG_WD-1:0] shadow;
  logic                   shadow_valid;

  logic                   wr_ctrl_c;
  logic                   latch_req_c;
  logic                   rst_req_c;
  logic                   busy_c;
  logic [REG_WD-1:0]      rd_mux_c;
  logic                   wr_data_unused_c;

  // A combined latch+reset write is treated as a soft reset only
  assign wr_ctrl_c   = i_wr_en && (iv_addr == ADDR_WD'(ADDR_CTRL));
  assign latch_req_c = wr_ctrl_c && iv_wr_data[CTRL_LATCH_BIT] && !iv_wr_data[CTRL_RST_BIT];
  assign rst_req_c   = wr_ctrl_c && iv_wr_data[CTRL_RST_BIT];
  assign busy_c      = (state != ST_IDLE);

  assign wr_data_unused_c = ^iv_wr_data[REG_WD-1:CTRL_RST_BIT+1];

  // Latch FSM; the shadow only ever changes in CAPT, and requests while busy are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      o_timestamp_load <= 1'b0;
      shadow           <= '0;
      shadow_valid     <= 1'b0;
    end else begin
      o_timestamp_load <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (latch_req_c) begin
            state            <= ST_LOAD;
            o_timestamp_load <= 1'b1;
          end
        end
        ST_LOAD: state <= ST_CAPT;
        ST_CAPT: begin
          shadow       <= iv_timestamp_reg;
          shadow_valid <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (rst_req_c) begin
        shadow_valid <= 1'b0;
      end
    end
  end

  // Read mux over current (pre-write) register state
  always_comb begin
    rd_mux_c = '0;
    if (iv_addr == ADDR_WD'(ADDR_CTRL)) begin
      rd_mux_c[CTRL_BUSY_BIT]  = busy_c;
      rd_mux_c[CTRL_VALID_BIT] = shadow_valid;
    end else begin
      for (int unsigned k = 0; k < NUM_TS_WORDS; k++) begin
        if (iv_addr == ADDR_WD'(ADDR_TS0 + k)) begin
          rd_mux_c = shadow[k*REG_WD +: REG_WD];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_rd_valid <= 1'b0;
      ov_rd_data <= '0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        ov_rd_data <= rd_mux_c;
      end
    end
  end

  pulse_stretch #(
    .LEN (RST_LEN)
  ) u_rst_pulse (
    .clk   (clk),
    .reset (reset),
    .start (rst_req_c),
    .pulse (o_timestamp_rst)
  );

endmodule

// File: tb/tb_timestamp_reg_if.sv
// Directed self-checking bench for timestamp_reg_if: reset, latch path, busy drop, soft reset, decode edges.
`timescale 1ns/1ps
module tb_timestamp_reg_if;

  localparam int unsigned LONG_REG_WD = 64;
  localparam int unsigned REG_WD      = 16;
  localparam int unsigned ADDR_WD     = 9;
  localparam int unsigned RST_LEN     = 4;

  localparam logic [ADDR_WD-1:0] A_CTRL = 9'h030;
  localparam logic [ADDR_WD-1:0] A_TS0  = 9'h031;
  localparam logic [ADDR_WD-1:0] A_TS1  = 9'h032;
  localparam logic [ADDR_WD-1:0] A_BAD  = 9'h035;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   i_wr_en;
  logic                   i_rd_en;
  logic [ADDR_WD-1:0]     iv_addr;
  logic [REG_WD-1:0]      iv_wr_data;
  logic [REG_WD-1:0]      ov_rd_data;
  logic                   o_rd_valid;
  logic                   o_timestamp_load;
  logic [LONG_REG_WD-1:0] iv_timestamp_reg;
  logic                   o_timestamp_rst;

  int n_checks = 0;
  int n_fail   = 0;

  timestamp_reg_if #(
    .LONG_REG_WD (LONG_REG_WD),
    .REG_WD      (REG_WD),
    .ADDR_WD     (ADDR_WD),
    .RST_LEN     (RST_LEN)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_wr_en          (i_wr_en),
    .i_rd_en          (i_rd_en),
    .iv_addr          (iv_addr),
    .iv_wr_data       (iv_wr_data),
    .ov_rd_data       (ov_rd_data),
    .o_rd_valid       (o_rd_valid),
    .o_timestamp_load (o_timestamp_load),
    .iv_timestamp_reg (iv_timestamp_reg),
    .o_timestamp_rst  (o_timestamp_rst)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_WD-1:0] addr, input logic [REG_WD-1:0] data);
    i_wr_en = 1'b1; iv_addr = addr; iv_wr_data = data;
    tick();
    i_wr_en = 1'b0; iv_wr_data = '0;
  endtask

  task automatic do_read(input logic [ADDR_WD-1:0] addr, output logic [REG_WD-1:0] data,
                         output logic valid);
    i_rd_en = 1'b1; iv_addr = addr;
    tick();
    i_rd_en = 1'b0;
    data = ov_rd_data; valid = o_rd_valid;
  endtask

  task automatic test_reset();
    logic [REG_WD-1:0] rd; logic vld;
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if ({o_timestamp_load, o_timestamp_rst, o_rd_valid} !== 3'b000) begin n_fail++;
      $display("FAIL reset_ctl_outs: got %b expected 000", {o_timestamp_load, o_timestamp_rst, o_rd_valid}); end
    n_checks++; if (ov_rd_data !== 16'h0000) begin n_fail++;
      $display("FAIL reset_rd_data: got %h expected 0000", ov_rd_data); end
    reset = 1'b0;
    tick();
    do_read(A_CTRL, rd, vld);
    n_checks++; if (vld !== 1'b1) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 1", vld); end
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL reset_ctrl_read: got %h expected 0000", rd); end
    tick();
    n_checks++; if (o_rd_valid !== 1'b0) begin n_fail++;
      $display("FAIL rd_valid_drop: got %b expected 0", o_rd_valid); end
  endtask

  task automatic test_reset_in_load();
    logic [REG_WD-1:0] rd; logic vld;
    iv_timestamp_reg = 64'hDEAD_BEEF_CAFE_F00D;
    do_write(A_CTRL, 16'h0001);
    n_checks++; if (o_timestamp_load !== 1'b1) begin n_fail++;
      $display("FAIL ril_load_pulse: got %b expected 1", o_timestamp_load); end
    reset = 1'b1;
    tick();
    n_checks++; if (o_timestamp_load !== 1'b0) begin n_fail++;
      $display("FAIL ril_load_abort: got %b expected 0", o_timestamp_load); end
    reset = 1'b0;
    repeat (2) tick();
    n_checks++; if (o_timestamp_load !== 1'b0) begin n_fail++;
      $display("FAIL ril_no_reload: got %b expected 0", o_timestamp_load); end
    do_read(A_TS0, rd, vld);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL ril_no_capture: got %h expected 0000", rd); end
    do_read(A_CTRL, rd, vld);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL ril_ctrl: got %h expected 0000", rd); end
  endtask

  task automatic test_latch();
    logic [REG_WD-1:0] rd; logic vld;
    logic [REG_WD-1:0] exp_ts [4];
    exp_ts[0] = 16'hCDEF; exp_ts[1] = 16'h89AB; exp_ts[2] = 16'h4567; exp_ts[3] = 16'h0123;
    iv_timestamp_reg = 64'h0123_4567_89AB_CDEF;
    do_write(A_CTRL, 16'h0001);
    n_checks++; if (o_timestamp_load !== 1'b1) begin n_fail++;
      $display("FAIL latch_load_n1: got %b expected 1", o_timestamp_load); end
    do_read(A_CTRL, rd, vld);
    n_checks++; if (rd !== 16'h0001) begin n_fail++; $display("FAIL latch_busy_read: got %h expected 0001", rd); end
    n_checks++; if (o_timestamp_load !== 1'b0) begin n_fail++;
      $display("FAIL latch_load_n2: got %b expected 0", o_timestamp_load); end
    tick();
    for (int k = 0; k < 4; k++) begin
      do_read(A_TS0 + ADDR_WD'(k), rd, vld);
      n_checks++; if (rd !== exp_ts[k] || vld !== 1'b1) begin n_fail++;
        $display("FAIL latch_ts%0d: got %h valid %b expected %h valid 1", k, rd, vld, exp_ts[k]); end
    end
    do_read(A_CTRL, rd, vld);
    n_checks++; if (rd !== 16'h0002) begin n_fail++; $display("FAIL latch_ctrl_valid: got %h expected 0002", rd); end
  endtask

  task automatic test_busy_drop();
    logic [REG_WD-1:0] rd; logic vld;
    iv_timestamp_reg = 64'h1111_2222_3333_4444;
    do_write(A_CTRL, 16'h0001);
    do_write(A_CTRL, 16'h0001);
    n_checks++; if (o_timestamp_load !== 1'b0) begin n_fail++;
      $display("FAIL busy_no_second_load: got %b expected 0", o_timestamp_load); end
    do_read(A_TS0, rd, vld);
    n_checks++; if (rd !== 16'hCDEF) begin n_fail++; $display("FAIL busy_old_shadow: got %h expected cdef", rd); end
    n_checks++; if (o_timestamp_load !== 1'b0) begin n_fail++;
      $display("FAIL busy_no_late_load: got %b expected 0", o_timestamp_load); end
    tick();
    do_read(A_TS0, rd, vld);
    n_checks++; if (rd !== 16'h4444) begin n_fail++; $display("FAIL busy_new_shadow: got %h expected 4444", rd); end
  endtask

  task automatic test_soft_reset();
    logic [REG_WD-1:0] rd; logic vld;
    logic [7:0] pat; logic [9:0] pat2; logic ld_seen;
    pat = '0; pat2 = '0; ld_seen = 1'b0;
    do_write(A_CTRL, 16'h0003);
    for (int i = 0; i < 8; i++) begin
      pat[i] = o_timestamp_rst; ld_seen = ld_seen | o_timestamp_load;
      tick();
    end
    n_checks++; if (pat !== 8'h0F) begin n_fail++; $display("FAIL srst_pulse_shape: got %b expected 00001111", pat); end
    n_checks++; if (ld_seen !== 1'b0) begin n_fail++; $display("FAIL srst_no_load: got %b expected 0", ld_seen); end
    do_read(A_CTRL, rd, vld);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL srst_ctrl: got %h expected 0000", rd); end
    do_read(A_TS0, rd, vld);
    n_checks++; if (rd !== 16'h4444) begin n_fail++; $display("FAIL srst_shadow_kept: got %h expected 4444", rd); end
    // second soft-reset write two cycles in restarts the count
    do_write(A_CTRL, 16'h0002);
    for (int i = 0; i < 10; i++) begin
      pat2[i] = o_timestamp_rst;
      if (i == 1) begin
        i_wr_en = 1'b1; iv_addr = A_CTRL; iv_wr_data = 16'h0002;
      end
      tick();
      i_wr_en = 1'b0; iv_wr_data = '0;
    end
    n_checks++; if (pat2 !== 10'b00_0011_1111) begin n_fail++;
      $display("FAIL srst_restart: got %b expected 0000111111", pat2); end
  endtask

  task automatic test_unmapped();
    logic [REG_WD-1:0] rd; logic vld;
    do_read(A_BAD, rd, vld);
    n_checks++; if (rd !== 16'h0000 || vld !== 1'b1) begin n_fail++;
      $display("FAIL unmapped_read: got %h valid %b expected 0000 valid 1", rd, vld); end
    do_write(A_TS1, 16'hFFFF);
    do_write(A_BAD, 16'h0001);
    n_checks++; if (o_timestamp_load !== 1'b0) begin n_fail++;
      $display("FAIL unmapped_write_load: got %b expected 0", o_timestamp_load); end
    do_read(A_TS1, rd, vld);
    n_checks++; if (rd !== 16'h3333) begin n_fail++; $display("FAIL ts1_unchanged: got %h expected 3333", rd); end
  endtask

  task automatic test_simultaneous();
    logic [REG_WD-1:0] rd; logic vld;
    i_wr_en = 1'b1; i_rd_en = 1'b1; iv_addr = A_CTRL; iv_wr_data = 16'h0001;
    tick();
    i_wr_en = 1'b0; i_rd_en = 1'b0; iv_wr_data = '0;
    n_checks++; if (ov_rd_data !== 16'h0000 || o_rd_valid !== 1'b1) begin n_fail++;
      $display("FAIL simul_pre_write_read: got %h valid %b expected 0000 valid 1", ov_rd_data, o_rd_valid); end
    n_checks++; if (o_timestamp_load !== 1'b1) begin n_fail++;
      $display("FAIL simul_write_load: got %b expected 1", o_timestamp_load); end
    repeat (2) tick();
    do_read(A_CTRL, rd, vld);
    n_checks++; if (rd !== 16'h0002) begin n_fail++; $display("FAIL simul_ctrl_after: got %h expected 0002", rd); end
  endtask

  initial begin
    reset = 1'b1; i_wr_en = 1'b0; i_rd_en = 1'b0;
    iv_addr = '0; iv_wr_data = '0; iv_timestamp_reg = '0;
    test_reset();
    test_reset_in_load();
    test_latch();
    test_busy_drop();
    test_soft_reset();
    test_unmapped();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
